// File: rtl/prog_loader.sv
// Serial program loader: assembles little-endian 32-bit words from a byte stream,
// writes them to instruction memory, verifies an XOR checksum, then releases the core.
module prog_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic [AW:0]   len_words,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

  logic [2:0]  state_reg, state_next;
  logic [AW:0] word_idx_reg, word_idx_next;
  logic [AW:0] len_reg, len_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [7:0]  xor_reg, xor_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        err_reg, err_next;
  logic        done_reg, done_next;

  logic accept;
  logic lane_we;
  logic len_ok;

  assign byte_ready = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign accept     = byte_valid && byte_ready;
  assign lane_we    = accept && (state_reg == S_LOAD);
  assign len_ok     = (len_words != '0) && (len_words <= DEPTH_L);

  // Each byte lane captures only when the byte counter points at it, so a
  // stalled stream keeps the partially assembled word intact.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_next[8*gi +: 8] = (lane_we && (byte_cnt_reg == 2'(gi)))
                                   ? byte_data : wdata_reg[8*gi +: 8];
  end

  always_comb begin
    state_next    = state_reg;
    word_idx_next = word_idx_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    xor_next      = xor_reg;
    err_next      = err_reg;
    done_next     = 1'b0;
    case (state_reg)
      S_IDLE, S_RUN: begin
        if (load_req) begin
          if (len_ok) begin
            state_next    = S_LOAD;
            word_idx_next = '0;
            byte_cnt_next = '0;
            xor_next      = '0;
            err_next      = 1'b0;
            len_next      = len_words;
          end else begin
            state_next = S_IDLE;
            err_next   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          xor_next      = xor_reg ^ byte_data;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_next = word_idx_reg + IDX_ONE;
        byte_cnt_next = '0;
        state_next    = ((word_idx_reg + IDX_ONE) == len_reg) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        if (accept) begin
          if (byte_data == xor_reg) begin
            state_next = S_RUN;
            done_next  = 1'b1;
          end else begin
            state_next = S_IDLE;
            err_next   = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      word_idx_reg <= '0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      xor_reg      <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_idx_reg <= word_idx_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      xor_reg      <= xor_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
    end
  end

  assign imem_we    = (state_reg == S_WRITE);
  assign imem_addr  = {{(29-AW){1'b0}}, word_idx_reg, 2'b00};
  assign imem_wdata = wdata_reg;
  assign cpu_rst    = (state_reg != S_RUN);
  assign busy       = (state_reg == S_LOAD) || (state_reg == S_WRITE) || (state_reg == S_CHECK);
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte streams built from a word/checksum model, random
// stalls, rejects, mid-load reset and load_req corner cases.
module tb_prog_loader;

  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int LW    = AW + 1;

  logic          clk;
  logic          rst;
  logic          load_req;
  logic [AW:0]   len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: memory writes, done pulses and cpu_rst falling edges.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int we_total   = 0;
  int done_total = 0;
  int done_cyc   = -1;
  int fall_cyc   = -1;
  logic prev_cpu_rst = 1'b1;
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      we_total++;
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
  end

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [7:0] bq[$];
  int we_base;
  int done_base;

  // Stream = 4*len data bytes followed by their XOR (optionally corrupted).
  task automatic build(input int len, input bit bad);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    bq.delete();
    for (int i = 0; i < 4*len; i++) begin
      b = 8'($urandom);
      bq.push_back(b);
      x ^= b;
    end
    bq.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic start_load(input int len);
    @(negedge clk);
    load_req  = 1'b1;
    len_words = LW'(len);
    we_base   = we_total;
    done_base = done_total;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic feed(input int from, input int to, input bit rnd, output int first_cyc);
    int idx;
    int budget;
    idx = from;
    budget = 4000;
    first_cyc = -1;
    while (idx < to && budget > 0) begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = bq[idx];
      if (byte_valid && byte_ready) begin
        if (idx == 0) first_cyc = cyc;
        idx++;
      end
      @(negedge clk);
      budget--;
    end
    byte_valid = 1'b0;
    if (idx < to) check("feed_timeout", 32'(idx), 32'(to));
  endtask

  task automatic check_outcome(input int len, input bit bad, input int first_cyc, input bit timed);
    logic [31:0] w;
    repeat (2) @(negedge clk);
    check("wr_count", 32'(we_total - we_base), 32'(len));
    for (int i = 0; i < len && (we_base + i) < we_total; i++) begin
      w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      check("wr_addr", wr_addr_q[we_base + i], 32'(4*i));
      check("wr_data", wr_data_q[we_base + i], w);
    end
    check("busy_after", 32'(busy), 32'(0));
    if (!bad) begin
      check("done_pulses", 32'(done_total - done_base), 32'(1));
      check("cpu_rst_run", 32'(cpu_rst), 32'(0));
      check("err_ok", 32'(err), 32'(0));
      check("cpu_rst_fall_cyc", 32'(fall_cyc), 32'(done_cyc));
      if (timed) check("load_cycles", 32'(done_cyc - first_cyc), 32'(5*len + 1));
    end else begin
      check("done_pulses_bad", 32'(done_total - done_base), 32'(0));
      check("err_bad", 32'(err), 32'(1));
      check("cpu_rst_bad", 32'(cpu_rst), 32'(1));
      check("ready_bad", 32'(byte_ready), 32'(0));
    end
    $display("load len=%0d bad=%0d writes=%0d done=%0d err=%0d",
             len, bad, we_total - we_base, done_total - done_base, err);
  endtask

  task automatic reject(input int len);
    start_load(len);
    for (int i = 0; i < 3; i++) begin
      check("rej_ready", 32'(byte_ready), 32'(0));
      @(negedge clk);
    end
    check("rej_err", 32'(err), 32'(1));
    check("rej_cpu_rst", 32'(cpu_rst), 32'(1));
    check("rej_busy", 32'(busy), 32'(0));
    check("rej_writes", 32'(we_total - we_base), 32'(0));
    $display("reject len=%0d err=%0d", len, err);
  endtask

  task automatic full_load(input int len, input bit bad, input bit rnd);
    int first;
    start_load(len);
    feed(0, 4*len + 1, rnd, first);
    check_outcome(len, bad, first, !rnd);
  endtask

  initial begin
    int first;
    int len;
    bit bad;
    bit rnd;
    rst        = 1'b1;
    load_req   = 1'b0;
    len_words  = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset state, during and right after reset
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'(1));
    check("rst_ready", 32'(byte_ready), 32'(0));
    check("rst_we", 32'(imem_we), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpu_rst", 32'(cpu_rst), 32'(1));
    check("post_rst_ready", 32'(byte_ready), 32'(0));

    // Two-word program, good checksum, continuous stream
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    start_load(2);
    check("load_busy", 32'(busy), 32'(1));
    check("load_ready", 32'(byte_ready), 32'(1));
    feed(0, 9, 1'b0, first);
    check_outcome(2, 1'b0, first, 1'b1);

    // One word, wrong checksum byte
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    full_load(1, 1'b1, 1'b0);

    // Length rejects: zero, then good load to clear err, then DEPTH+1
    reject(0);
    build(1, 1'b0);
    full_load(1, 1'b0, 1'b0);
    reject(DEPTH + 1);

    // Same three-word stream with random stalls and continuously
    build(3, 1'b0);
    full_load(3, 1'b0, 1'b1);
    full_load(3, 1'b0, 1'b0);

    // Reset after the sixth byte of a four-word load
    build(4, 1'b0);
    start_load(4);
    feed(0, 6, 1'b0, first);
    #2 rst = 1'b1;
    #1;
    check("abort_writes", 32'(we_total - we_base), 32'(1));
    check("abort_cpu_rst", 32'(cpu_rst), 32'(1));
    check("abort_ready", 32'(byte_ready), 32'(0));
    check("abort_we", 32'(imem_we), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_err", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    build(2, 1'b0);
    full_load(2, 1'b0, 1'b1);

    // load_req during LOAD is ignored; load_req in RUN restarts at address 0
    build(2, 1'b0);
    start_load(2);
    feed(0, 3, 1'b0, first);
    load_req  = 1'b1;
    len_words = LW'(1);
    @(negedge clk);
    load_req = 1'b0;
    feed(3, 9, 1'b0, first);
    check_outcome(2, 1'b0, first, 1'b0);
    build(1, 1'b0);
    start_load(1);
    check("rerun_cpu_rst", 32'(cpu_rst), 32'(1));
    check("rerun_busy", 32'(busy), 32'(1));
    feed(0, 5, 1'b1, first);
    check_outcome(1, 1'b0, first, 1'b0);

    // Randomised loads, including the full-depth boundary
    for (int t = 0; t < 8; t++) begin
      len = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
      bad = ($urandom_range(0, 3) == 0);
      rnd = 1'($urandom_range(0, 1));
      build(len, bad);
      full_load(len, bad, rnd);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
